// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA raster generator.
// Holds the standard mode tables and the porch-to-sync arithmetic used by the top level.
package vga_timing_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        bit h_pol;
        bit v_pol;
    } vga_mode_t;

    // 640x480@60, 25 MHz pixel clock, both syncs active-low.
    localparam vga_mode_t MODE_640X480 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        h_pol: 1'b0, v_pol: 1'b0
    };

    // 800x600@60, 40 MHz pixel clock, both syncs active-high.
    localparam vga_mode_t MODE_800X600 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        h_pol: 1'b1, v_pol: 1'b1
    };

    typedef struct packed {
        int total;
        int sync_start;
        int sync_end;
    } axis_timing_t;

    // Sync occupies [sync_start, sync_end) on the axis count, after active + front porch.
    function automatic axis_timing_t axis_timing(input int active, input int fp,
                                                 input int sync, input int bp);
        axis_timing_t t;
        t.total      = active + fp + sync + bp;
        t.sync_start = active + fp;
        t.sync_end   = active + fp + sync;
        return t;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster output bundle from the timing generator to renderers and the VGA pins.
interface vga_timing_if #(
    parameter int CW = 10
);
    logic          hsync;
    logic          vsync;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          video_on;
    logic          line_start;
    logic          frame_start;
    logic          vblank;

    modport master (
        output hsync, vsync, x, y, video_on, line_start, frame_start, vblank
    );

    modport slave (
        input hsync, vsync, x, y, video_on, line_start, frame_start, vblank
    );
endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping 0..TOTAL-1 counter; wrap is the combinational carry for the cycle it rolls over.
module vga_axis_counter #(
    parameter int TOTAL = 800,
    parameter int CW    = 10
) (
    input  logic          clk25,
    input  logic          rst_n,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          wrap
);
    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = inc && (cnt_q == LAST);
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: two axis counters, sync/active decode,
// and one output register stage so every output carries the same counter state.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = MODE_640X480.h_active,
    parameter int H_FP     = MODE_640X480.h_fp,
    parameter int H_SYNC   = MODE_640X480.h_sync,
    parameter int H_BP     = MODE_640X480.h_bp,
    parameter int V_ACTIVE = MODE_640X480.v_active,
    parameter int V_FP     = MODE_640X480.v_fp,
    parameter int V_SYNC   = MODE_640X480.v_sync,
    parameter int V_BP     = MODE_640X480.v_bp,
    parameter bit H_POL    = MODE_640X480.h_pol,
    parameter bit V_POL    = MODE_640X480.v_pol,
    parameter int CW       = 10
) (
    input  logic         clk25,
    input  logic         rst_n,
    input  logic         en,
    vga_timing_if.master vga
);
    localparam axis_timing_t HT = axis_timing(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam axis_timing_t VT = axis_timing(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(HT.sync_start);
    localparam logic [CW-1:0] HS_END   = CW'(HT.sync_end);
    localparam logic [CW-1:0] VS_START = CW'(VT.sync_start);
    localparam logic [CW-1:0] VS_END   = CW'(VT.sync_end);

    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          h_wrap;
    logic          v_wrap;

    vga_axis_counter #(.TOTAL(HT.total), .CW(CW)) u_h_cnt (
        .clk25 (clk25),
        .rst_n (rst_n),
        .inc   (en),
        .cnt   (hc),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(.TOTAL(VT.total), .CW(CW)) u_v_cnt (
        .clk25 (clk25),
        .rst_n (rst_n),
        .inc   (en & h_wrap),
        .cnt   (vc),
        .wrap  (v_wrap)
    );

    logic hsync_d, vsync_d, video_on_d, line_start_d, frame_start_d, vblank_d;
    logic hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q, vblank_q;
    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q;

    // Decode from the pre-increment counters; the register stage below aligns them with x/y.
    always_comb begin
        hsync_d       = ((hc >= HS_START) && (hc < HS_END)) ? H_POL : ~H_POL;
        vsync_d       = ((vc >= VS_START) && (vc < VS_END)) ? V_POL : ~V_POL;
        video_on_d    = (hc < H_ACT_C) && (vc < V_ACT_C);
        line_start_d  = (hc == '0);
        frame_start_d = (hc == '0) && (vc == '0);
        vblank_d      = (vc >= V_ACT_C);
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            x_q           <= '0;
            y_q           <= '0;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
        end else if (en) begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            x_q           <= hc;
            y_q           <= vc;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            vblank_q      <= vblank_d;
        end else begin
            // Levels hold while paused; strobes drop so a held position never re-fires.
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.video_on    = video_on_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.vblank      = vblank_q;

    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench: three generator builds (640x480, 800x600 active-high, tiny raster)
// share clock, reset and enable; expected outputs are queued per edge and checked at negedge.
module tb_vga_timing_gen;
    localparam int CW = 11;
    localparam int NI = 3;

    // Instance 0: 640x480, instance 1: 800x600 POL=1, instance 2: 16x10 raster (H_POL=1).
    localparam int HA[NI] = '{640, 800, 8};
    localparam int HF[NI] = '{16, 40, 2};
    localparam int HS[NI] = '{96, 128, 3};
    localparam int HB[NI] = '{48, 88, 3};
    localparam int VA[NI] = '{480, 600, 6};
    localparam int VF[NI] = '{10, 1, 1};
    localparam int VS[NI] = '{2, 4, 2};
    localparam int VB[NI] = '{33, 23, 1};
    localparam bit HP[NI] = '{1'b0, 1'b1, 1'b1};
    localparam bit VP[NI] = '{1'b0, 1'b1, 1'b0};
    // Hand-computed totals and sync windows [lo, hi).
    localparam int HTOT[NI]  = '{800, 1056, 16};
    localparam int VTOT[NI]  = '{525, 628, 10};
    localparam int HS_LO[NI] = '{656, 840, 10};
    localparam int HS_HI[NI] = '{752, 968, 13};
    localparam int VS_LO[NI] = '{490, 601, 7};
    localparam int VS_HI[NI] = '{492, 605, 9};

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          von;
        logic          ls;
        logic          fs;
        logic          vb;
    } out_t;
    typedef out_t [NI-1:0] trio_t;

    logic clk25 = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    out_t obs[NI];

    always #5 clk25 = ~clk25;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        vga_timing_if #(.CW(CW)) vif ();
        vga_timing_gen #(
            .H_ACTIVE(HA[gi]), .H_FP(HF[gi]), .H_SYNC(HS[gi]), .H_BP(HB[gi]),
            .V_ACTIVE(VA[gi]), .V_FP(VF[gi]), .V_SYNC(VS[gi]), .V_BP(VB[gi]),
            .H_POL(HP[gi]), .V_POL(VP[gi]), .CW(CW)
        ) u_dut (
            .clk25 (clk25),
            .rst_n (rst_n),
            .en    (en),
            .vga   (vif)
        );
        assign obs[gi] = '{vif.hsync, vif.vsync, vif.x, vif.y, vif.video_on,
                           vif.line_start, vif.frame_start, vif.vblank};
    end

    trio_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;

    // Reference raster position per instance and the last expected output.
    int   mh[NI];
    int   mv[NI];
    out_t held[NI];

    function automatic out_t expect_at(input int i, input int h, input int v);
        out_t o;
        o.hs  = (h >= HS_LO[i] && h < HS_HI[i]) ? HP[i] : !HP[i];
        o.vs  = (v >= VS_LO[i] && v < VS_HI[i]) ? VP[i] : !VP[i];
        o.x   = CW'(h);
        o.y   = CW'(v);
        o.von = (h < HA[i]) && (v < VA[i]);
        o.ls  = (h == 0);
        o.fs  = (h == 0) && (v == 0);
        o.vb  = (v >= VA[i]);
        return o;
    endfunction

    task automatic tick(input bit r, input bit e);
        trio_t ex;
        rst_n = r;
        en    = e;
        @(posedge clk25);
        for (int i = 0; i < NI; i++) begin
            if (!r) begin
                held[i] = '{!HP[i], !VP[i], '0, '0, 1'b0, 1'b0, 1'b0, 1'b0};
                mh[i] = 0;
                mv[i] = 0;
            end else if (e) begin
                held[i] = expect_at(i, mh[i], mv[i]);
                if (mh[i] == HTOT[i] - 1) begin
                    mh[i] = 0;
                    mv[i] = (mv[i] == VTOT[i] - 1) ? 0 : mv[i] + 1;
                end else begin
                    mh[i] = mh[i] + 1;
                end
            end else begin
                held[i].ls = 1'b0;
                held[i].fs = 1'b0;
            end
            ex[i] = held[i];
        end
        exp_q.push_back(ex);
        #1;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Structural measurements, taken from DUT outputs and checked against hand values at the end.
    int  since_fs = 0, gap_s = -1, ls_cnt = 0, ls_per_frame = -1, vs_cnt = 0, vs_per_frame = -1;
    bit  seen_fs = 1'b0, line0_done = 1'b0;
    int  hs0_cnt = 0, von0_cnt = 0;

    always @(negedge clk25) begin : monitor
        trio_t ex;
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            cyc++;
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (obs[i] !== ex[i]) begin
                    n_fail++;
                    if (n_fail <= 20)
                        $display("FAIL out[%0d] cyc %0d: got hs=%b vs=%b x=%0d y=%0d von=%b ls=%b fs=%b vb=%b, expected hs=%b vs=%b x=%0d y=%0d von=%b ls=%b fs=%b vb=%b",
                                 i, cyc, obs[i].hs, obs[i].vs, obs[i].x, obs[i].y, obs[i].von,
                                 obs[i].ls, obs[i].fs, obs[i].vb, ex[i].hs, ex[i].vs, ex[i].x,
                                 ex[i].y, ex[i].von, ex[i].ls, ex[i].fs, ex[i].vb);
                end
            end
            since_fs++;
            if (obs[2].fs === 1'b1) begin
                if (seen_fs) begin
                    gap_s        = since_fs;
                    ls_per_frame = ls_cnt;
                    vs_per_frame = vs_cnt;
                end
                seen_fs  = 1'b1;
                since_fs = 0;
                ls_cnt   = 0;
                vs_cnt   = 0;
            end
            if (obs[2].ls === 1'b1) ls_cnt++;
            if (obs[2].vs === 1'b0) vs_cnt++;
            if (!line0_done) begin
                if (obs[0].y == CW'(1)) line0_done = 1'b1;
                else begin
                    if (obs[0].hs === 1'b0) hs0_cnt++;
                    if (obs[0].von === 1'b1) von0_cnt++;
                end
            end
        end
    end

    initial begin
        #2;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);      // reset overrides en
        for (int i = 0; i < 8800; i++) tick(1'b1, 1'b1);   // last output: x=799, y=10
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);     // frozen, no strobes
        for (int i = 0; i < 301; i++) tick(1'b1, 1'b1);    // resume at (0,11) up to x=300
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b1);      // mid-line reset
        for (int i = 0; i < 2000; i++) tick(1'b1, 1'b1);
        repeat (3) @(negedge clk25);

        check_int("queue_drained", exp_q.size(), 0);
        check_int("small_frame_period", gap_s, 160);
        check_int("small_line_starts_per_frame", ls_per_frame, 10);
        check_int("small_vsync_active_cycles", vs_per_frame, 32);
        check_int("vga_line0_hsync_low_cycles", hs0_cnt, 96);
        check_int("vga_line0_video_on_cycles", von0_cnt, 640);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
